// File: rtl/nw_pkg.sv
// Shared types and helpers for the Needleman-Wunsch score-matrix block.
//   nw_state_e   : init sequencer state
//   W_DEFAULT    : default score width
//   idx_width()  : index width needed to address 0..n
//   sat_mul_gap(): k*gap clamped to a w-bit two's-complement range
package nw_pkg;

  typedef enum logic [1:0] {IDLE, INIT, READY} nw_state_e;

  localparam int W_DEFAULT = 9;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int sat_mul_gap(input int k, input int gap, input int w);
    longint p;
    longint hi;
    longint lo;
    p  = longint'(k) * longint'(gap);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (p > hi)
      p = hi;
    else if (p < lo)
      p = lo;
    return int'(p);
  endfunction

endpackage

// File: rtl/nw_init_seq.sv
// Boundary init sequencer: walks k = 0..N and emits the boundary write
// M[0][k] = M[k][0] = sat(k*GAP).
//   clk, rst        : clock, synchronous active-high reset
//   start_init      : begins (or restarts) initialisation
//   busy, init_done : registered status flags
//   bnd_we, bnd_k, bnd_data : boundary write strobe, index and value
//
// state | meaning
// IDLE  | nothing initialised since reset
// INIT  | writing boundary cell k each cycle
// READY | boundaries valid, matrix open for traffic
module nw_init_seq
  import nw_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = W_DEFAULT,
  parameter int GAP = -1,
  parameter int IW  = idx_width(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_init,
  output logic                busy,
  output logic                init_done,
  output logic                bnd_we,
  output logic [IW-1:0]       bnd_k,
  output logic signed [W-1:0] bnd_data
);

  localparam logic [IW-1:0] K_LAST = IW'(N);

  nw_state_e     state;
  logic [IW-1:0] k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start_init) begin
            state     <= INIT;
            k         <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
          end
        end
        INIT: begin
          if (start_init) begin
            k <= '0;
          end else if (k == K_LAST) begin
            state     <= READY;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else begin
            k <= k + IW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          k         <= '0;
          busy      <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  assign bnd_we   = (state == INIT);
  assign bnd_k    = k;
  assign bnd_data = W'(sat_mul_gap(int'(k), GAP, W));

endmodule

// File: rtl/nw_score_matrix.sv
// (N+1)x(N+1) signed score matrix with built-in boundary init, one interior
// write per cycle and a registered diag/up/left neighbour read.
//   clk, rst                      : clock, synchronous active-high reset
//   start_init / busy / init_done : boundary init control and status
//   upd_valid/upd_i/upd_j/upd_score, upd_ready : interior write M[i+1][j+1]
//   nb_req/nb_i/nb_j              : neighbour read request for cell (i,j)
//   nb_valid, diag, up, left      : M[i][j], M[i][j+1], M[i+1][j]
//   err                           : pulse on out-of-range index
module nw_score_matrix
  import nw_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = W_DEFAULT,
  parameter int GAP = -1,
  parameter int IW  = idx_width(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_init,
  output logic                busy,
  output logic                init_done,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [IW-1:0]       upd_i,
  input  logic [IW-1:0]       upd_j,
  input  logic signed [W-1:0] upd_score,
  input  logic                nb_req,
  input  logic [IW-1:0]       nb_i,
  input  logic [IW-1:0]       nb_j,
  output logic                nb_valid,
  output logic signed [W-1:0] diag,
  output logic signed [W-1:0] up,
  output logic signed [W-1:0] left,
  output logic                err
);

  localparam logic [IW-1:0] N_IDX = IW'(N);

  logic signed [W-1:0] mem [0:N][0:N];

  logic                bnd_we;
  logic [IW-1:0]       bnd_k;
  logic signed [W-1:0] bnd_data;

  nw_init_seq #(.N(N), .W(W), .GAP(GAP), .IW(IW)) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .start_init (start_init),
    .busy       (busy),
    .init_done  (init_done),
    .bnd_we     (bnd_we),
    .bnd_k      (bnd_k),
    .bnd_data   (bnd_data)
  );

  assign upd_ready = init_done && !busy;

  logic upd_oob, nb_oob, upd_acc, nb_acc;
  assign upd_oob = (upd_i >= N_IDX) || (upd_j >= N_IDX);
  assign nb_oob  = (nb_i >= N_IDX) || (nb_j >= N_IDX);
  assign upd_acc = upd_valid && upd_ready && !upd_oob;
  assign nb_acc  = nb_req && upd_ready && !nb_oob;

  // Accepted indices are < N, so +1 still fits in IW bits.
  logic [IW-1:0] wr_r, wr_c, rd_r1, rd_c1;
  assign wr_r  = upd_i + IW'(1);
  assign wr_c  = upd_j + IW'(1);
  assign rd_r1 = nb_i + IW'(1);
  assign rd_c1 = nb_j + IW'(1);

  // Storage is deliberately not reset: interior cells survive rst and re-init.
  always_ff @(posedge clk) begin
    if (bnd_we) begin
      mem[0][bnd_k] <= bnd_data;
      mem[bnd_k][0] <= bnd_data;
    end
    if (upd_acc)
      mem[wr_r][wr_c] <= upd_score;
  end

  // Write-first: a same-cycle write to a read target wins over the array.
  logic signed [W-1:0] diag_n, up_n, left_n;
  always_comb begin
    diag_n = mem[nb_i][nb_j];
    up_n   = mem[nb_i][rd_c1];
    left_n = mem[rd_r1][nb_j];
    if (upd_acc) begin
      if (wr_r == nb_i && wr_c == nb_j)   diag_n = upd_score;
      if (wr_r == nb_i && wr_c == rd_c1)  up_n   = upd_score;
      if (wr_r == rd_r1 && wr_c == nb_j)  left_n = upd_score;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nb_valid <= 1'b0;
      err      <= 1'b0;
      diag     <= '0;
      up       <= '0;
      left     <= '0;
    end else begin
      nb_valid <= nb_acc;
      err      <= upd_ready && ((upd_valid && upd_oob) || (nb_req && nb_oob));
      if (nb_acc) begin
        diag <= diag_n;
        up   <= up_n;
        left <= left_n;
      end
    end
  end

endmodule

// File: tb/tb_nw_score_matrix.sv
// Self-checking bench for nw_score_matrix: directed vector table, random
// traffic against a plain-array matrix model, reset/re-init sequences and a
// second saturating instance.
module tb_nw_score_matrix;

  localparam int N   = 4;
  localparam int W   = 9;
  localparam int GAP = -1;
  localparam int DC  = 99999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                start_init = 1'b0;
  logic                busy, init_done, upd_ready, nb_valid, err;
  logic                upd_valid = 1'b0;
  logic [2:0]          upd_i = '0, upd_j = '0;
  logic signed [W-1:0] upd_score = '0;
  logic                nb_req = 1'b0;
  logic [2:0]          nb_i = '0, nb_j = '0;
  logic signed [W-1:0] diag, up, left;

  nw_score_matrix #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .busy(busy),
    .init_done(init_done), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_i(upd_i), .upd_j(upd_j), .upd_score(upd_score), .nb_req(nb_req),
    .nb_i(nb_i), .nb_j(nb_j), .nb_valid(nb_valid), .diag(diag), .up(up),
    .left(left), .err(err)
  );

  logic            start2 = 1'b0;
  logic            busy2, done2, ready2, nbv2, err2;
  logic            upd_valid2 = 1'b0;
  logic [2:0]      upd_i2 = '0, upd_j2 = '0;
  logic signed [5:0] upd_score2 = '0;
  logic            nb_req2 = 1'b0;
  logic [2:0]      nb_i2 = '0, nb_j2 = '0;
  logic signed [5:0] diag2, up2, left2;

  nw_score_matrix #(.N(4), .W(6), .GAP(-12)) dut_sat (
    .clk(clk), .rst(rst), .start_init(start2), .busy(busy2),
    .init_done(done2), .upd_valid(upd_valid2), .upd_ready(ready2),
    .upd_i(upd_i2), .upd_j(upd_j2), .upd_score(upd_score2), .nb_req(nb_req2),
    .nb_i(nb_i2), .nb_j(nb_j2), .nb_valid(nbv2), .diag(diag2), .up(up2),
    .left(left2), .err(err2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int uv, ui, uj, us;
    int nr, ni, nj;
    int e_nbv, e_err, e_d, e_u, e_l;
  } vec_t;

  vec_t tbl[17];
  int   mm[N+1][N+1];

  task automatic chk(input string name, input int act, input int exp);
    if (exp == DC) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int uv, input int ui, input int uj, input int us,
                       input int nr, input int ni, input int nj);
    upd_valid = (uv != 0);
    upd_i     = 3'(ui);
    upd_j     = 3'(uj);
    upd_score = 9'(us);
    nb_req    = (nr != 0);
    nb_i      = 3'(ni);
    nb_j      = 3'(nj);
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      cyc();
    end
  endtask

  function automatic int bnd(input int k, input int gap, input int w);
    int lim, v;
    lim = 1 << (w - 1);
    v = k * gap;
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
    return v;
  endfunction

  initial begin
    int cnt, ui, uj, us, ni, nj, e_err, e_nbv, ed, eu, el;
    bit uv, nr, ek;

    tbl[0]  = '{0,0,0,0,   1,0,0, 1,0, 0,-1,-1};
    tbl[1]  = '{0,0,0,0,   1,0,3, 1,0, -3,-4,DC};
    tbl[2]  = '{1,0,0,1,   0,0,0, 0,0, -3,-4,DC};
    tbl[3]  = '{1,0,1,12,  0,0,0, 0,0, DC,DC,DC};
    tbl[4]  = '{1,1,0,21,  0,0,0, 0,0, DC,DC,DC};
    tbl[5]  = '{1,1,1,2,   0,0,0, 0,0, DC,DC,DC};
    tbl[6]  = '{0,0,0,0,   1,1,1, 1,0, 1,12,21};
    tbl[7]  = '{0,0,0,0,   1,2,2, 1,0, 2,DC,DC};
    tbl[8]  = '{1,2,1,32,  1,2,2, 1,0, 2,DC,32};
    tbl[9]  = '{0,0,0,0,   1,2,2, 1,0, 2,DC,32};
    tbl[10] = '{1,4,0,77,  0,0,0, 0,1, 2,DC,32};
    tbl[11] = '{1,0,4,77,  0,0,0, 0,1, 2,DC,32};
    tbl[12] = '{0,0,0,0,   1,5,0, 0,1, 2,DC,32};
    tbl[13] = '{0,0,0,0,   1,0,4, 0,1, 2,DC,32};
    tbl[14] = '{0,0,0,0,   1,3,0, 1,0, -3,DC,-4};
    tbl[15] = '{1,4,4,5,   1,0,0, 1,1, 0,-1,-1};
    tbl[16] = '{0,0,0,0,   0,0,0, 0,0, 0,-1,-1};

    // Reset state
    cyc(); cyc();
    chk("rst busy", busy, 0);
    chk("rst init_done", init_done, 0);
    chk("rst nb_valid", nb_valid, 0);
    chk("rst err", err, 0);
    chk("rst diag", diag, 0);
    chk("rst up", up, 0);
    chk("rst left", left, 0);
    chk("rst upd_ready", upd_ready, 0);
    rst = 1'b0;

    // Requests before init are silently ignored
    drive(1, 4, 0, 5, 1, 5, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("idle err", err, 0);
    chk("idle nb_valid", nb_valid, 0);

    // Boundary init
    start_init = 1'b1;
    cyc();
    start_init = 1'b0;
    wait_busy(cnt);
    chk("init busy_len", cnt, N + 1);
    chk("init done", init_done, 1);
    chk("init upd_ready", upd_ready, 1);

    // Directed vector table
    for (int t = 0; t < 17; t++) begin
      drive(tbl[t].uv, tbl[t].ui, tbl[t].uj, tbl[t].us, tbl[t].nr, tbl[t].ni, tbl[t].nj);
      cyc();
      chk($sformatf("v%0d nb_valid", t), nb_valid, tbl[t].e_nbv);
      chk($sformatf("v%0d err", t), err, tbl[t].e_err);
      chk($sformatf("v%0d diag", t), diag, tbl[t].e_d);
      chk($sformatf("v%0d up", t), up, tbl[t].e_u);
      chk($sformatf("v%0d left", t), left, tbl[t].e_l);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Model: boundaries from the gap rule, interior filled with random writes
    for (int k = 0; k <= N; k++) begin
      mm[0][k] = bnd(k, GAP, W);
      mm[k][0] = bnd(k, GAP, W);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        us = int'($urandom_range(0, 511)) - 256;
        drive(1, i, j, us, 0, 0, 0);
        cyc();
        mm[i+1][j+1] = us;
      end
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Random traffic against the model
    ek = 0; ed = 0; eu = 0; el = 0;
    for (int c = 0; c < 400; c++) begin
      uv = 1'($urandom_range(0, 1));
      nr = 1'($urandom_range(0, 3) != 0);
      ui = ($urandom_range(0, 9) == 0) ? N + int'($urandom_range(0, 1)) : int'($urandom_range(0, N - 1));
      uj = ($urandom_range(0, 9) == 0) ? N + int'($urandom_range(0, 1)) : int'($urandom_range(0, N - 1));
      ni = ($urandom_range(0, 9) == 0) ? N + int'($urandom_range(0, 1)) : int'($urandom_range(0, N - 1));
      nj = ($urandom_range(0, 9) == 0) ? N + int'($urandom_range(0, 1)) : int'($urandom_range(0, N - 1));
      us = int'($urandom_range(0, 511)) - 256;
      drive(uv, ui, uj, us, nr, ni, nj);
      cyc();
      e_err = int'((uv && (ui >= N || uj >= N)) || (nr && (ni >= N || nj >= N)));
      if (uv && ui < N && uj < N) mm[ui+1][uj+1] = us;
      if (nr && ni < N && nj < N) begin
        ed = mm[ni][nj];
        eu = mm[ni][nj+1];
        el = mm[ni+1][nj];
        ek = 1;
        e_nbv = 1;
      end else begin
        e_nbv = 0;
      end
      chk($sformatf("rnd%0d nb_valid", c), nb_valid, e_nbv);
      chk($sformatf("rnd%0d err", c), err, e_err);
      if (ek) begin
        chk($sformatf("rnd%0d diag", c), diag, ed);
        chk($sformatf("rnd%0d up", c), up, eu);
        chk($sformatf("rnd%0d left", c), left, el);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of init
    start_init = 1'b1;
    cyc();
    start_init = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst init_done", init_done, 0);
    chk("midrst upd_ready", upd_ready, 0);
    drive(1, 0, 0, 99, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("midrst nb_valid", nb_valid, 0);
    chk("midrst err", err, 0);

    // Re-init with a restart partway through
    start_init = 1'b1;
    cyc();
    start_init = 1'b0;
    cyc();
    start_init = 1'b1;
    cyc();
    start_init = 1'b0;
    wait_busy(cnt);
    chk("restart busy_len", cnt, N + 1);
    chk("restart init_done", init_done, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    cyc();
    chk("reinit nb_valid", nb_valid, 1);
    chk("reinit diag", diag, 0);
    chk("reinit up", up, -1);
    chk("reinit left", left, -1);
    drive(0, 0, 0, 0, 1, 1, 1);
    cyc();
    chk("keep diag", diag, mm[1][1]);
    chk("keep up", up, mm[1][2]);
    chk("keep left", left, mm[2][1]);
    drive(0, 0, 0, 0, 1, 3, 3);
    cyc();
    chk("keep33 diag", diag, mm[3][3]);
    chk("keep33 up", up, mm[3][4]);
    chk("keep33 left", left, mm[4][3]);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Saturating boundaries: W=6, GAP=-12
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 50) begin
      cnt++;
      cyc();
    end
    chk("sat init_done", done2, 1);
    nb_req2 = 1'b1; nb_i2 = 3'd0; nb_j2 = 3'd2;
    cyc();
    chk("sat nb_valid", nbv2, 1);
    chk("sat M02", diag2, bnd(2, -12, 6));
    chk("sat M03", up2, bnd(3, -12, 6));
    nb_i2 = 3'd2; nb_j2 = 3'd0;
    cyc();
    nb_req2 = 1'b0;
    chk("sat M20", diag2, -24);
    chk("sat M30", left2, -32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
